// File: rtl/vga_writer_pkg.sv
// Timing defaults, register map, bit positions and colour-bar table for vga_pixel_writer.
package vga_writer_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned HCNT_W   = $clog2(H_TOTAL);
    localparam int unsigned VCNT_W   = $clog2(V_TOTAL);

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned RGB_W      = 24;
    localparam logic [RGB_W-1:0] BLANK_RGB = 24'h000000;

    typedef enum logic [1:0] {
        ADDR_PIXEL  = 2'd0,
        ADDR_CTRL   = 2'd1,
        ADDR_STATUS = 2'd2
    } addr_e;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_CLR_BIT  = 1;
    localparam int unsigned CTRL_TP_BIT   = 2;
    localparam int unsigned ST_LEVEL_W    = 9;
    localparam int unsigned ST_UF_BIT     = 9;
    localparam int unsigned ST_OF_BIT     = 10;
    localparam int unsigned ST_VBLANK_BIT = 11;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int unsigned BAR_COUNT = 8;
    localparam int unsigned BAR_W     = H_ACTIVE / BAR_COUNT;

    // Eight equal-width vertical bars, bar index found by threshold compare rather than division.
    function automatic rgb_t bar_colour(input logic [HCNT_W-1:0] h);
        logic [2:0] idx;
        rgb_t       c;
        idx = 3'd0;
        for (int unsigned i = 1; i < BAR_COUNT; i++) begin
            if (h >= HCNT_W'(i * BAR_W)) idx = 3'(i);
        end
        unique case (idx)
            3'd0:    c = rgb_t'(24'hFFFFFF);
            3'd1:    c = rgb_t'(24'hFFFF00);
            3'd2:    c = rgb_t'(24'h00FFFF);
            3'd3:    c = rgb_t'(24'h00FF00);
            3'd4:    c = rgb_t'(24'hFF00FF);
            3'd5:    c = rgb_t'(24'hFF0000);
            3'd6:    c = rgb_t'(24'h0000FF);
            default: c = rgb_t'(24'h000000);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pixel_writer_fifo.sv
// Synchronous pixel FIFO; push while full is accepted only when a pop frees a slot in the same cycle.
module pixel_fifo
    import vga_writer_pkg::*;
#(
    parameter int unsigned WIDTH = RGB_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ST_LEVEL_W-1:0] level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = ST_LEVEL_W'(count_q);

    always_comb begin
        pop_ok_c  = pop_i && !empty_o;
        push_ok_c = push_i && (!full_o || pop_ok_c);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read past the count.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/vga_pixel_writer.sv
// Avalon-MM write slave feeding a VGA DAC from a pixel FIFO, with its own sync/blank timing.
// Optional colour-bar generator enabled by defining VGA_WRITER_TESTPATTERN_EN.
module vga_pixel_writer
    import vga_writer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             chipselect,
    input  logic             write,
    input  logic             read,
    input  logic [1:0]       address,
    input  logic [RGB_W-1:0] writedata,
    output logic [RGB_W-1:0] readdata,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_n
);

    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic              enable_q, enable_d;
    logic              uf_q, uf_d;
    logic              of_q, of_d;
    rgb_t              rgb_q, rgb_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_n_q, blank_n_d;
    logic [RGB_W-1:0]  readdata_q, readdata_d;

    addr_e                 addr_c;
    logic                  push_c, pop_c, ctrl_wr_c;
    logic                  active_c, slot_c, vblank_c;
    logic                  uf_set_c, of_set_c;
    logic                  tp_c;
    rgb_t                  pattern_rgb_c;
    logic [RGB_W-1:0]      fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [ST_LEVEL_W-1:0] fifo_level;

`ifdef VGA_WRITER_TESTPATTERN_EN
    logic tp_q, tp_d;

    always_comb begin
        tp_d = tp_q;
        if (ctrl_wr_c) tp_d = writedata[CTRL_TP_BIT];
    end

    always_ff @(posedge clk) begin
        if (reset) tp_q <= 1'b0;
        else       tp_q <= tp_d;
    end

    assign tp_c          = tp_q;
    assign pattern_rgb_c = bar_colour(hcnt_q);
`else
    assign tp_c          = 1'b0;
    assign pattern_rgb_c = rgb_t'(BLANK_RGB);
`endif

    // Bus decode and per-slot pop/underflow/overflow qualifiers.
    always_comb begin
        addr_c    = addr_e'(address);
        push_c    = chipselect && write && (addr_c == ADDR_PIXEL);
        ctrl_wr_c = chipselect && write && (addr_c == ADDR_CTRL);
        active_c  = (hcnt_q < HCNT_W'(H_ACTIVE)) && (vcnt_q < VCNT_W'(V_ACTIVE));
        vblank_c  = (vcnt_q >= VCNT_W'(V_ACTIVE));
        slot_c    = enable_q && pix_en;
        pop_c     = slot_c && active_c && !tp_c && !fifo_empty;
        uf_set_c  = slot_c && active_c && !tp_c && fifo_empty;
        of_set_c  = push_c && fifo_full && !pop_c;
    end

    pixel_fifo #(
        .WIDTH (RGB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_c),
        .push_data_i (writedata),
        .pop_i       (pop_c),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        enable_d   = enable_q;
        uf_d       = uf_q | uf_set_c;
        of_d       = of_q | of_set_c;
        rgb_d      = rgb_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        blank_n_d  = blank_n_q;
        readdata_d = readdata_q;

        if (ctrl_wr_c) begin
            enable_d = writedata[CTRL_EN_BIT];
            if (writedata[CTRL_CLR_BIT]) begin
                uf_d = 1'b0;
                of_d = 1'b0;
            end
        end

        if (!enable_q) begin
            hcnt_d    = '0;
            vcnt_d    = '0;
            rgb_d     = '0;
            hs_d      = 1'b1;
            vs_d      = 1'b1;
            blank_n_d = 1'b0;
        end else if (pix_en) begin
            // All four VGA outputs are formed from the same pre-advance counter state.
            blank_n_d = active_c;
            hs_d      = !((hcnt_q >= HCNT_W'(HS_START)) && (hcnt_q < HCNT_W'(HS_END)));
            vs_d      = !((vcnt_q >= VCNT_W'(VS_START)) && (vcnt_q < VCNT_W'(VS_END)));
            if (!active_c)       rgb_d = '0;
            else if (tp_c)       rgb_d = pattern_rgb_c;
            else if (!fifo_empty) rgb_d = rgb_t'(fifo_head);
            else                 rgb_d = rgb_t'(BLANK_RGB);

            if (hcnt_q == HCNT_W'(H_TOTAL - 1)) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VCNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + VCNT_W'(1);
            end else begin
                hcnt_d = hcnt_q + HCNT_W'(1);
            end
        end

        if (chipselect && read) begin
            readdata_d = '0;
            unique case (addr_c)
                ADDR_CTRL: begin
                    readdata_d[CTRL_EN_BIT] = enable_q;
                    readdata_d[CTRL_TP_BIT] = tp_c;
                end
                ADDR_STATUS: begin
                    readdata_d[ST_LEVEL_W-1:0] = fifo_level;
                    readdata_d[ST_UF_BIT]      = uf_q;
                    readdata_d[ST_OF_BIT]      = of_q;
                    readdata_d[ST_VBLANK_BIT]  = vblank_c;
                end
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            enable_q   <= 1'b0;
            uf_q       <= 1'b0;
            of_q       <= 1'b0;
            rgb_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_n_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            enable_q   <= enable_d;
            uf_q       <= uf_d;
            of_q       <= of_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_n_q  <= blank_n_d;
            readdata_q <= readdata_d;
        end
    end

    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_n = blank_n_q;
    assign readdata    = readdata_q;

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Randomised bench for vga_pixel_writer checked every cycle against a slot-level behavioural model.
// Colour-bar checks are compiled only when VGA_WRITER_TESTPATTERN_EN is defined.
module tb_vga_pixel_writer;

    localparam int H_ACT = 640;
    localparam int H_TOT = 800;
    localparam int V_ACT = 480;
    localparam int V_TOT = 525;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, pix_en, chipselect, write, read;
    logic [1:0]  address;
    logic [23:0] writedata;
    logic [23:0] readdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_n;

    vga_pixel_writer dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_n (VGA_BLANK_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue for the FIFO and a frame position (h, v) per pixel slot.
    logic [23:0] m_q[$];
    bit          m_en, m_tp, m_uf, m_of;
    int          m_h, m_v;
    logic [23:0] e_rgb, e_rd;
    bit          e_hs, e_vs, e_blank;

`ifdef VGA_WRITER_TESTPATTERN_EN
    function automatic logic [23:0] bar_rgb(input int h);
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return bars[h / (H_ACT / 8)];
    endfunction
`endif

    always @(posedge clk) begin : model
        bit act, uf_set, of_set;
        int lvl;
        if (reset) begin
            m_q.delete();
            m_en = 0; m_tp = 0; m_uf = 0; m_of = 0; m_h = 0; m_v = 0;
            e_rgb = 24'h0; e_hs = 1; e_vs = 1; e_blank = 0; e_rd = 24'h0;
        end else begin
            uf_set = 0;
            of_set = 0;
            lvl    = m_q.size();
            if (chipselect && read) begin
                e_rd = 24'h0;
                if (address == 2'd1) begin
                    e_rd[0] = m_en;
                    e_rd[2] = m_tp;
                end else if (address == 2'd2) begin
                    e_rd[8:0] = lvl[8:0];
                    e_rd[9]   = m_uf;
                    e_rd[10]  = m_of;
                    e_rd[11]  = (m_v >= V_ACT);
                end
            end
            if (!m_en) begin
                e_rgb = 24'h0; e_hs = 1; e_vs = 1; e_blank = 0; m_h = 0; m_v = 0;
            end else if (pix_en) begin
                act     = (m_h < H_ACT) && (m_v < V_ACT);
                e_blank = act;
                e_hs    = !(m_h >= 656 && m_h < 752);
                e_vs    = !(m_v >= 490 && m_v < 492);
                if (!act) e_rgb = 24'h0;
`ifdef VGA_WRITER_TESTPATTERN_EN
                else if (m_tp) e_rgb = bar_rgb(m_h);
`endif
                else if (m_q.size() > 0) e_rgb = m_q.pop_front();
                else begin
                    e_rgb  = 24'h000000;
                    uf_set = 1;
                end
                m_h++;
                if (m_h == H_TOT) begin
                    m_h = 0;
                    m_v = (m_v + 1) % V_TOT;
                end
            end
            if (chipselect && write && address == 2'd0) begin
                if (m_q.size() < DEPTH) m_q.push_back(writedata);
                else of_set = 1;
            end
            m_uf = m_uf | uf_set;
            m_of = m_of | of_set;
            if (chipselect && write && address == 2'd1) begin
                m_en = writedata[0];
`ifdef VGA_WRITER_TESTPATTERN_EN
                m_tp = writedata[2];
`endif
                if (writedata[1]) begin
                    m_uf = 0;
                    m_of = 0;
                end
            end
        end
    end

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("rgb",     {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e_rgb});
            check_eq("hs",      {31'h0, VGA_HS},      {31'h0, e_hs});
            check_eq("vs",      {31'h0, VGA_VS},      {31'h0, e_vs});
            check_eq("blank_n", {31'h0, VGA_BLANK_n}, {31'h0, e_blank});
            check_eq("readdata", {8'h0, readdata},    {8'h0, e_rd});
        end
    end

    task automatic cyc(input bit pe, input bit cs, input bit wr, input bit rd,
                       input logic [1:0] a, input logic [23:0] d);
        pix_en = pe; chipselect = cs; write = wr; read = rd; address = a; writedata = d;
        @(negedge clk);
    endtask

    task automatic idle(input bit pe);
        cyc(pe, 1'b0, 1'b0, 1'b0, 2'd0, 24'h0);
    endtask

    task automatic push(input logic [23:0] d);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, d);
    endtask

    task automatic wr_ctrl(input logic [23:0] d);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, d);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 24'h0);
    endtask

    initial begin
        int          first_low, low_cnt, k, guard;
        logic [23:0] seen [4];
        reset = 1'b1; pix_en = 0; chipselect = 0; write = 0; read = 0; address = 2'd0; writedata = 24'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_on = 1;
        check_eq("rst_rgb",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        check_eq("rst_hs",    {31'h0, VGA_HS}, 32'h1);
        check_eq("rst_vs",    {31'h0, VGA_VS}, 32'h1);
        check_eq("rst_blank", {31'h0, VGA_BLANK_n}, 32'h0);
        check_eq("rst_rd",    {8'h0, readdata}, 32'h0);

        // Three primaries then underflow; HS window over two lines at pix_en = clk/2.
        push(24'hFF0000);
        push(24'h00FF00);
        push(24'h0000FF);
        wr_ctrl(24'h1);
        first_low = -1; low_cnt = 0; k = 0;
        for (int i = 0; i < 2 * 2 * H_TOT; i++) begin
            idle(i % 2 == 0);
            if (i % 2 == 0) begin
                if (k < 4) seen[k] = {VGA_R, VGA_G, VGA_B};
                if (VGA_HS == 1'b0) begin
                    low_cnt++;
                    if (first_low < 0) first_low = k;
                end
                k++;
            end
        end
        check_eq("px0", {8'h0, seen[0]}, 32'hFF0000);
        check_eq("px1", {8'h0, seen[1]}, 32'h00FF00);
        check_eq("px2", {8'h0, seen[2]}, 32'h0000FF);
        check_eq("px3_blank", {8'h0, seen[3]}, 32'h000000);
        check_eq("hs_first_low", first_low, 656);
        check_eq("hs_low_2lines", low_cnt, 192);
        rd_reg(2'd2);
        check_eq("st_uf", {31'h0, readdata[9]}, 32'h1);
        check_eq("st_level0", {23'h0, readdata[8:0]}, 32'h0);

        // Overflow with enable off.
        wr_ctrl(24'h0);
        for (int i = 0; i < 17; i++) push(24'($urandom));
        rd_reg(2'd2);
        check_eq("st_level16", {23'h0, readdata[8:0]}, 32'd16);
        check_eq("st_of", {31'h0, readdata[10]}, 32'h1);
`ifdef VGA_WRITER_TESTPATTERN_EN
        wr_ctrl(24'h5);
        for (int i = 0; i < H_ACT; i++) begin
            idle(1'b1);
            if (i == 0)   check_eq("bar_px0",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);
            if (i == 80)  check_eq("bar_px80",  {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFF00);
            if (i == 639) check_eq("bar_px639", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000000);
        end
        rd_reg(2'd2);
        check_eq("tp_level16", {23'h0, readdata[8:0]}, 32'd16);
        check_eq("tp_no_uf", {31'h0, readdata[9]}, 32'h0);
`endif
        wr_ctrl(24'h3);
        rd_reg(2'd2);
        check_eq("clr_flags", {30'h0, readdata[10:9]}, 32'h0);
        rd_reg(2'd1);
        check_eq("ctrl_rd", {8'h0, readdata}, 32'h1);

        // Empty FIFO: push and pop in the same cycle.
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        check_eq("rst2_rd", {8'h0, readdata}, 32'h0);
        wr_ctrl(24'h1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 24'hA5A5A5);
        rd_reg(2'd2);
        check_eq("pp_level1", {23'h0, readdata[8:0]}, 32'd1);
        check_eq("pp_uf", {31'h0, readdata[9]}, 32'h1);

        // Disable mid-line at hcnt 300, then restart from the top-left corner.
        guard = 0;
        while (m_h != 300 && guard < 2000) begin
            idle(1'b1);
            guard++;
        end
        check_eq("wait_h300_timeout", {31'h0, guard >= 2000}, 32'h0);
        wr_ctrl(24'h0);
        idle(1'b0);
        check_eq("dis_hs",    {31'h0, VGA_HS}, 32'h1);
        check_eq("dis_vs",    {31'h0, VGA_VS}, 32'h1);
        check_eq("dis_blank", {31'h0, VGA_BLANK_n}, 32'h0);
        check_eq("dis_rgb",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        push(24'h123456);
        wr_ctrl(24'h1);
        idle(1'b1);
        check_eq("reen_px0",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h123456);
        check_eq("reen_blank", {31'h0, VGA_BLANK_n}, 32'h1);

        // Reset mid-frame flushes the FIFO.
        push(24'h111111);
        push(24'h222222);
        reset = 1'b1;
        idle(1'b1);
        reset = 1'b0;
        rd_reg(2'd2);
        check_eq("rst_flush", {8'h0, readdata}, 32'h0);

        // Random traffic against the model.
        wr_ctrl(24'h1);
        for (int i = 0; i < 20000; i++) begin
            int          r;
            bit          pe;
            logic [23:0] d;
            r  = int'($urandom_range(0, 99));
            pe = bit'($urandom_range(0, 1));
            d  = 24'($urandom);
            if (r < 45) begin
                cyc(pe, 1'b1, 1'b1, 1'b0, 2'd0, d);
            end else if (r < 47) begin
                d[0] = ($urandom_range(0, 7) != 0);
                cyc(pe, 1'b1, 1'b1, 1'b0, 2'd1, d);
            end else if (r < 57) begin
                cyc(pe, 1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 24'h0);
            end else if (r < 60) begin
                cyc(pe, 1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), d);
            end else begin
                idle(pe);
            end
        end

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pixel_writer.md
# vga_pixel_writer

CPU-facing Avalon-MM write slave that streams 24-bit RGB pixels out to a VGA DAC/connector, generating HSYNC/VSYNC/BLANK timing itself. Transmit-side counterpart of the frame-capture path: software pushes pixels into an internal FIFO; the timing generator pops one pixel per active pixel slot. Sits between the HPS lightweight bridge and the VGA pins, in a single clock domain with a pixel-enable strobe.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (pixel slots)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (lines)
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, 4..256)
- BLANK_RGB, 24'h000000, colour driven on underflow
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  one-cycle pixel strobe (e.g. clk/2 for 25 MHz)
- chipselect, write, read  in  1 each  Avalon-MM strobes
- address  in  2  0=PIXEL (W), 1=CTRL (R/W), 2=STATUS (R)
- writedata  in  24  {R,G,B} for PIXEL; CTRL bit0 enable, bit1 clear-flags (W1C pulse), bit2 test-pattern
- readdata  out  24  read data, registered
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_HS, VGA_VS  out  1 each  active-low syncs
- VGA_BLANK_n  out  1  high during active region

## Operation
- Counters hcnt (0..H_total-1), vcnt (0..V_total-1), H_total=800, V_total=525 at defaults; advance only on pix_en with enable=1; hcnt wrap increments vcnt; vcnt wraps to 0.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE. HS low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752). VS low for vcnt in [490,492).
- Active slot: pop FIFO head to RGB. If FIFO empty: drive BLANK_RGB, set sticky underflow. Non-active slot: RGB=0, no pop.
- PIXEL write: push writedata. Full and no pop this cycle: drop, set sticky overflow. Full with simultaneous pop: push accepted. Empty with simultaneous push and pop: pop sees empty (underflow, no bypass), push accepted.
- CTRL write: enable<=bit0, test-pattern<=bit2; bit1=1 clears underflow and overflow (clear wins over same-cycle set). CTRL read returns {21'b0, tp, 1'b0, enable}.
- STATUS read: bits[8:0] FIFO level, bit9 underflow, bit10 overflow, bit11 in vertical blank (vcnt>=V_ACTIVE), rest 0.
- enable=0: counters forced to 0, HS=VS=1, BLANK_n=0, RGB=0, FIFO contents kept, no pops. Re-enable starts at (0,0), first pixel of frame.
- Reset (any time): all state cleared, FIFO flushed, flags 0, enable 0.
- Reset values: VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_n=0, readdata=0.

## Timing
- VGA outputs registered; RGB, HS, VS, BLANK_n all update on the same pix_en edge from the same counter state, one clk after counter value is formed (aligned, latency 1).
- readdata valid on cycle after chipselect&&read (read latency 1); holds otherwise.
- Write accepted in the cycle asserted; no waitrequest. Level visible in STATUS on next cycle.
- Between pix_en strobes outputs hold.

## Configuration
- VGA_WRITER_TESTPATTERN_EN defined: CTRL bit2=1 replaces FIFO data with 8 vertical colour bars (80 px each at H_ACTIVE=640: white, yellow, cyan, green, magenta, red, blue, black), no pops, no underflow.
- Undefined: bit2 ignored, reads 0; pattern logic absent.

## Structure
- Package vga_writer_pkg: timing defaults, derived H_TOTAL/V_TOTAL/sync bounds, address enum (ADDR_PIXEL, ADDR_CTRL, ADDR_STATUS), CTRL/STATUS bit-position constants, colour-bar table.
- Sub-module pixel_fifo: synchronous FIFO (push/pop/full/empty/level, width 24, depth FIFO_DEPTH).

## Test plan
- Reset then enable, pix_en every 2nd clk: VGA_HS low exactly 96 slots starting hcnt=656, VS low lines 490-491, 800x525 slots per frame.
- Push 3 pixels 0xFF0000, 0x00FF00, 0x0000FF before enable: first 3 active slots show those, 4th shows BLANK_RGB, STATUS bit9=1.
- Push 17 pixels with enable=0 (depth 16): level=16, overflow=1; CTRL write 0x3: flags cleared, enable=1.
- Empty FIFO, push and pop in same cycle: underflow set, level=1 afterwards.
- Clear enable mid-line at hcnt=300: next cycle HS=VS=1, BLANK_n=0; re-enable restarts at (0,0); reset mid-frame flushes FIFO, level=0.
- With VGA_WRITER_TESTPATTERN_EN, CTRL=0x5: pixel 0 = 0xFFFFFF, pixel 80 = 0xFFFF00, pixel 639 = 0x000000, FIFO level unchanged.
